// File: rtl/food_spawn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : food_spawn_ctrl
// Purpose  : Draws food coordinates from the PRBS, rejects off-grid or occupied
//            cells, and falls back to a deterministic grid scan.
// Revision : 1.0 - initial release
// ============================================================================
module food_spawn_ctrl #(
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60,
    parameter int DRAW_GAP  = 7,
    parameter int MAX_TRIES = 15
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       spawn_req,
    input  logic [6:0] rnd,
    output logic       occ_req,
    output logic [6:0] occ_x,
    output logic [6:0] occ_y,
    input  logic       occ_ack,
    input  logic       occ_hit,
    output logic [6:0] food_x,
    output logic [6:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       spawn_fail
);

    localparam int c_gap_w  = (DRAW_GAP > 1) ? $clog2(DRAW_GAP) : 1;
    localparam int c_try_w  = $clog2(MAX_TRIES + 1);
    localparam int c_cells  = GRID_W * GRID_H;
    localparam int c_scan_w = $clog2(c_cells + 1);

    localparam logic [c_gap_w-1:0]  c_gap_load  = c_gap_w'(DRAW_GAP - 1);
    localparam logic [c_try_w-1:0]  c_max_tries = c_try_w'(MAX_TRIES);
    localparam logic [c_scan_w-1:0] c_cells_v   = c_scan_w'(c_cells);
    localparam logic [6:0]          c_x_last    = 7'(GRID_W - 1);
    localparam logic [6:0]          c_y_last    = 7'(GRID_H - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_X = 3'd1,
        ST_WAIT_Y = 3'd2,
        ST_QUERY  = 3'd3,
        ST_SCAN   = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_gap_w-1:0]    r_gap, w_gap_nxt;
    logic [c_try_w-1:0]    r_tries, w_tries_nxt, w_tries_inc;
    logic [c_scan_w-1:0]   r_scan_cnt, w_scan_cnt_nxt, w_scan_inc;
    logic [6:0]            r_cand_x, w_cand_x_nxt;
    logic [6:0]            r_occ_x, w_occ_x_nxt;
    logic [6:0]            r_occ_y, w_occ_y_nxt;
    logic [6:0]            r_food_x, w_food_x_nxt;
    logic [6:0]            r_food_y, w_food_y_nxt;
    logic                  r_occ_req, w_occ_req_nxt;
    logic                  r_food_valid, w_food_valid_nxt;
    logic                  r_spawn_fail, w_spawn_fail_nxt;
    logic                  w_ack;
    logic                  w_reject;
    logic [6:0]            w_start_x, w_start_y;
    logic [13:0]           w_next_cell;

    // Row-major successor of (x, y), wrapping at the grid's last cell.
    function automatic logic [13:0] next_cell(input logic [6:0] x, input logic [6:0] y);
        logic [6:0] nx;
        logic [6:0] ny;
        nx = x + 7'd1;
        ny = y;
        if (x == c_x_last) begin
            nx = 7'd0;
            ny = (y == c_y_last) ? 7'd0 : (y + 7'd1);
        end
        return {ny, nx};
    endfunction

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_gap_nxt        = r_gap;
        w_tries_nxt      = r_tries;
        w_scan_cnt_nxt   = r_scan_cnt;
        w_cand_x_nxt     = r_cand_x;
        w_occ_x_nxt      = r_occ_x;
        w_occ_y_nxt      = r_occ_y;
        w_food_x_nxt     = r_food_x;
        w_food_y_nxt     = r_food_y;
        w_occ_req_nxt    = r_occ_req;
        w_food_valid_nxt = r_food_valid;
        w_spawn_fail_nxt = r_spawn_fail;
        w_reject         = 1'b0;
        w_start_x        = 7'd0;
        w_start_y        = 7'd0;
        w_next_cell      = next_cell(r_occ_x, r_occ_y);
        w_tries_inc      = r_tries + c_try_w'(1);
        w_scan_inc       = r_scan_cnt + c_scan_w'(1);
        w_ack            = r_occ_req & occ_ack;

        case (r_state)
            ST_IDLE: begin
                if (spawn_req) begin
                    w_food_valid_nxt = 1'b0;
                    w_spawn_fail_nxt = 1'b0;
                    w_tries_nxt      = '0;
                    w_gap_nxt        = c_gap_load;
                    w_state_nxt      = ST_WAIT_X;
                end
            end
            ST_WAIT_X: begin
                if (r_gap != '0) begin
                    w_gap_nxt = r_gap - c_gap_w'(1);
                end else begin
                    w_cand_x_nxt = rnd;
                    if (rnd > c_x_last) begin
                        w_reject = 1'b1;
                    end else begin
                        w_gap_nxt   = c_gap_load;
                        w_state_nxt = ST_WAIT_Y;
                    end
                end
            end
            ST_WAIT_Y: begin
                if (r_gap != '0) begin
                    w_gap_nxt = r_gap - c_gap_w'(1);
                end else if (rnd > c_y_last) begin
                    w_reject = 1'b1;
                end else begin
                    w_occ_req_nxt = 1'b1;
                    w_occ_x_nxt   = r_cand_x;
                    w_occ_y_nxt   = rnd;
                    w_state_nxt   = ST_QUERY;
                end
            end
            ST_QUERY: begin
                if (w_ack) begin
                    w_occ_req_nxt = 1'b0;
                    if (occ_hit) begin
                        // A hit means both coordinates were on-grid, so the scan may resume past it.
                        w_reject               = 1'b1;
                        {w_start_y, w_start_x} = w_next_cell;
                    end else begin
                        w_food_x_nxt     = r_occ_x;
                        w_food_y_nxt     = r_occ_y;
                        w_food_valid_nxt = 1'b1;
                        w_state_nxt      = ST_IDLE;
                    end
                end
            end
            ST_SCAN: begin
                if (!r_occ_req) begin
                    w_occ_req_nxt = 1'b1;
                end else if (w_ack) begin
                    w_occ_req_nxt = 1'b0;
                    if (!occ_hit) begin
                        w_food_x_nxt     = r_occ_x;
                        w_food_y_nxt     = r_occ_y;
                        w_food_valid_nxt = 1'b1;
                        w_state_nxt      = ST_IDLE;
                    end else if (w_scan_inc == c_cells_v) begin
                        w_spawn_fail_nxt = 1'b1;
                        w_food_valid_nxt = 1'b0;
                        w_state_nxt      = ST_IDLE;
                    end else begin
                        w_scan_cnt_nxt             = w_scan_inc;
                        {w_occ_y_nxt, w_occ_x_nxt} = w_next_cell;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_reject) begin
            w_tries_nxt = w_tries_inc;
            if (w_tries_inc == c_max_tries) begin
                w_state_nxt    = ST_SCAN;
                w_occ_x_nxt    = w_start_x;
                w_occ_y_nxt    = w_start_y;
                w_scan_cnt_nxt = '0;
            end else begin
                w_state_nxt = ST_WAIT_X;
                w_gap_nxt   = c_gap_load;
            end
        end
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            r_gap        <= '0;
            r_tries      <= '0;
            r_scan_cnt   <= '0;
            r_cand_x     <= 7'd0;
            r_occ_x      <= 7'd0;
            r_occ_y      <= 7'd0;
            r_food_x     <= 7'd0;
            r_food_y     <= 7'd0;
            r_occ_req    <= 1'b0;
            r_food_valid <= 1'b0;
            r_spawn_fail <= 1'b0;
        end else begin
            r_gap        <= w_gap_nxt;
            r_tries      <= w_tries_nxt;
            r_scan_cnt   <= w_scan_cnt_nxt;
            r_cand_x     <= w_cand_x_nxt;
            r_occ_x      <= w_occ_x_nxt;
            r_occ_y      <= w_occ_y_nxt;
            r_food_x     <= w_food_x_nxt;
            r_food_y     <= w_food_y_nxt;
            r_occ_req    <= w_occ_req_nxt;
            r_food_valid <= w_food_valid_nxt;
            r_spawn_fail <= w_spawn_fail_nxt;
        end
    end

    assign occ_req    = r_occ_req;
    assign occ_x      = r_occ_x;
    assign occ_y      = r_occ_y;
    assign food_x     = r_food_x;
    assign food_y     = r_food_y;
    assign food_valid = r_food_valid;
    assign spawn_fail = r_spawn_fail;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_food_spawn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_food_spawn_ctrl
// Purpose  : Directed and random spawns scored against a grid-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_food_spawn_ctrl;

    localparam int GW    = 80;
    localparam int GH    = 60;
    localparam int DG    = 7;
    localparam int MT    = 4;
    localparam int CELLS = GW * GH;

    typedef struct { int x; int y; }            cell_t;
    typedef struct { bit fail; int x; int y; }  res_t;
    typedef struct { int val; bit then_query; } samp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spawn_req = 1'b0;
    logic [6:0] rnd = 7'd0;
    logic       occ_ack = 1'b0;
    logic       occ_hit = 1'b0;
    logic       occ_req;
    logic [6:0] occ_x, occ_y, food_x, food_y;
    logic       food_valid, busy, spawn_fail;

    food_spawn_ctrl #(.GRID_W(GW), .GRID_H(GH), .DRAW_GAP(DG), .MAX_TRIES(MT)) dut (
        .clock_25(clk), .reset(rst), .spawn_req(spawn_req), .rnd(rnd),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .busy(busy),
        .spawn_fail(spawn_fail)
    );

    always #5 clk = ~clk;

    bit      occ_map [CELLS];
    int      forced[$];
    samp_t   samp_q[$];
    cell_t   exp_q[$];
    res_t    exp_res[$];
    int      n_chk = 0;
    int      n_fail = 0;
    int      cd = 0;
    bit      in_q = 1'b0;
    int      ack_dly_max = 0;
    bit      ack_en = 1'b1;

    function automatic void check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void check2(input string name, input int ax, input int ay, input int ex, input int ey);
        n_chk++;
        if (ax != ex || ay != ey) begin
            n_fail++;
            $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d) (t=%0t)", name, ax, ay, ex, ey, $time);
        end
    endfunction

    function automatic int draw(input bit is_x);
        int lim;
        lim = is_x ? GW : GH;
        if (forced.size() > 0) return forced.pop_front();
        if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, lim - 1));
        return int'($urandom_range(lim, 127));
    endfunction

    // Reference: sample sequence, rejects, retries and the row-major fallback scan.
    task automatic model_spawn();
        int tries, x, y, idx, sx, sy;
        bit done, scan;
        tries = 0; sx = 0; sy = 0; done = 1'b0; scan = 1'b0;
        while (!done && !scan) begin
            x = draw(1'b1);
            samp_q.push_back('{val: x, then_query: 1'b0});
            if (x >= GW) begin
                tries++;
                if (tries == MT) begin scan = 1'b1; sx = 0; sy = 0; end
                continue;
            end
            y = draw(1'b0);
            if (y >= GH) begin
                samp_q.push_back('{val: y, then_query: 1'b0});
                tries++;
                if (tries == MT) begin scan = 1'b1; sx = 0; sy = 0; end
                continue;
            end
            samp_q.push_back('{val: y, then_query: 1'b1});
            exp_q.push_back('{x: x, y: y});
            if (!occ_map[y * GW + x]) begin
                exp_res.push_back('{fail: 1'b0, x: x, y: y});
                done = 1'b1;
            end else begin
                tries++;
                if (tries == MT) begin
                    scan = 1'b1;
                    idx  = (y * GW + x + 1) % CELLS;
                    sx   = idx % GW;
                    sy   = idx / GW;
                end
            end
        end
        if (scan) begin
            idx = sy * GW + sx;
            for (int k = 0; k < CELLS && !done; k++) begin
                exp_q.push_back('{x: idx % GW, y: idx / GW});
                if (!occ_map[idx]) begin
                    exp_res.push_back('{fail: 1'b0, x: idx % GW, y: idx / GW});
                    done = 1'b1;
                end
                idx = (idx + 1) % CELLS;
            end
            if (!done) exp_res.push_back('{fail: 1'b1, x: 0, y: 0});
        end
    endtask

    // Drives rnd (planned value only on the expected sample edge) and answers occupancy queries.
    initial begin : env
        int    ack_wait;
        samp_t s;
        ack_wait = -1;
        forever begin
            @(negedge clk);
            if (cd == 1 && samp_q.size() > 0) begin
                s    = samp_q.pop_front();
                rnd  = 7'(s.val);
                in_q = s.then_query;
                cd   = (s.then_query || samp_q.size() == 0) ? 0 : DG;
            end else begin
                rnd = 7'($urandom_range(0, 127));
                if (cd > 1) cd--;
            end
            if (occ_req && ack_en && !rst) begin
                if (ack_wait < 0) ack_wait = int'($urandom_range(0, ack_dly_max));
                if (ack_wait == 0) begin
                    occ_ack = 1'b1;
                    occ_hit = (int'(occ_x) < GW && int'(occ_y) < GH) ?
                              occ_map[int'(occ_y) * GW + int'(occ_x)] : 1'b1;
                    if (in_q) begin
                        in_q = 1'b0;
                        if (occ_hit && samp_q.size() > 0) cd = DG;
                    end
                    ack_wait = -1;
                end else begin
                    occ_ack = 1'b0;
                    occ_hit = 1'($urandom_range(0, 1));
                    ack_wait--;
                end
            end else begin
                occ_ack  = 1'b0;
                occ_hit  = 1'($urandom_range(0, 1));
                ack_wait = -1;
            end
        end
    end

    initial begin : monitor
        bit    prev_req, prev_busy;
        int    hx, hy;
        cell_t c;
        res_t  r;
        prev_req = 1'b0; prev_busy = 1'b0; hx = 0; hy = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req  = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (occ_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        check2("unexpected_query", int'(occ_x), int'(occ_y), -1, -1);
                    end else begin
                        c = exp_q.pop_front();
                        check2("query_xy", int'(occ_x), int'(occ_y), c.x, c.y);
                    end
                    hx = int'(occ_x);
                    hy = int'(occ_y);
                end else if (occ_req && prev_req) begin
                    check2("query_stable", int'(occ_x), int'(occ_y), hx, hy);
                end
                if (!busy && prev_busy) begin
                    if (exp_res.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        r = exp_res.pop_front();
                        check("done_fail", int'(spawn_fail), int'(r.fail));
                        check("done_valid", int'(food_valid), int'(!r.fail));
                        if (!r.fail) check2("food_xy", int'(food_x), int'(food_y), r.x, r.y);
                    end
                end
                prev_req  = occ_req;
                prev_busy = busy;
            end
        end
    end

    function automatic void flush_bench();
        forced.delete(); samp_q.delete(); exp_q.delete(); exp_res.delete();
        cd = 0; in_q = 1'b0;
    endfunction

    task automatic hard_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        flush_bench();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_map(input bit v);
        for (int i = 0; i < CELLS; i++) occ_map[i] = v;
    endtask

    task automatic start_spawn();
        model_spawn();
        @(negedge clk); #1;
        spawn_req = 1'b1;
        cd        = DG;
        @(posedge clk); #1;
        spawn_req = 1'b0;
        check("accept_busy_valid_fail", int'({busy, food_valid, spawn_fail}), 4);
    endtask

    task automatic do_spawn(input int lat_exp, input bit pulse_busy);
        int lat;
        lat = 0;
        start_spawn();
        while (busy && lat < 20000) begin
            @(negedge clk);
            if (busy) lat++;
            if (pulse_busy && busy && $urandom_range(0, 3) == 0) begin
                #1 spawn_req = 1'b1;
                @(posedge clk); #1 spawn_req = 1'b0;
            end
        end
        if (lat >= 20000) begin
            check("spawn_timeout", lat, -1);
            hard_reset();
        end else begin
            if (lat_exp >= 0) check("latency", lat, lat_exp);
            repeat (2) @(negedge clk);
            #2;
            check("queries_drained", exp_q.size(), 0);
            check("result_drained", exp_res.size(), 0);
        end
    endtask

    initial begin : stim
        int guard;
        set_map(1'b0);
        repeat (3) @(negedge clk);
        check("reset_values", int'({occ_req, occ_x, occ_y, food_x, food_y, food_valid, busy, spawn_fail}), 0);
        #1 rst = 1'b0;

        // Clean first draw: minimum latency 2*DRAW_GAP+1.
        ack_dly_max = 0;
        forced = '{25, 40};
        do_spawn(2 * DG + 1, 1'b0);

        // Out-of-range x costs exactly one extra gap.
        forced = '{100, 30, 45};
        do_spawn(3 * DG + 1, 1'b0);

        // Collision then a free cell, with ignored spawn_req pulses while busy.
        occ_map[10 * GW + 10] = 1'b1;
        forced = '{10, 10, 11, 12};
        do_spawn(4 * DG + 2, 1'b1);
        set_map(1'b0);

        // Four hits ending on the last cell: scan wraps to (0,0).
        occ_map[1 * GW + 1] = 1'b1; occ_map[2 * GW + 2] = 1'b1;
        occ_map[3 * GW + 3] = 1'b1; occ_map[59 * GW + 79] = 1'b1;
        forced = '{1, 1, 2, 2, 3, 3, 79, 59};
        do_spawn(8 * DG + 6, 1'b0);
        set_map(1'b0);

        // Range rejects only: scan starts at (0,0), skips an occupied origin.
        occ_map[0] = 1'b1;
        forced = '{100, 120, 5, 100, 127};
        do_spawn(5 * DG + 4, 1'b0);
        set_map(1'b0);

        // Reset while a query is outstanding.
        ack_en = 1'b0;
        forced = '{5, 6};
        start_spawn();
        guard = 0;
        while (!occ_req && guard < 100) begin @(negedge clk); guard++; end
        check("reset_test_query_seen", int'(occ_req), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", int'({occ_req, occ_x, occ_y, food_x, food_y, food_valid, busy, spawn_fail}), 0);
        check("reset_query_consumed", exp_q.size(), 0);
        flush_bench();
        @(negedge clk); #1 rst = 1'b0;
        ack_en = 1'b1;
        forced = '{70, 50};
        do_spawn(2 * DG + 1, 1'b0);

        // Fully occupied grid: exhaustive scan ends in spawn_fail.
        set_map(1'b1);
        do_spawn(-1, 1'b0);
        repeat (3) @(negedge clk);
        check("fail_held", int'({spawn_fail, food_valid, busy}), 4);
        set_map(1'b0);
        do_spawn(-1, 1'b0);

        // Random occupancy densities and ack delays.
        for (int it = 0; it < 30; it++) begin
            int dens;
            dens = (it % 5 == 4) ? 97 : int'($urandom_range(0, 90));
            for (int i = 0; i < CELLS; i++) occ_map[i] = ($urandom_range(0, 99) < dens);
            ack_dly_max = int'($urandom_range(0, 3));
            do_spawn(-1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/food_spawn_ctrl.md
# food_spawn_ctrl

Controller that draws the next food position from the free-running 7-bit PRBS generator and guarantees the position is on the grid and not on the snake. It sits between the game FSM, the PRBS output and the snake-body occupancy lookup. On each spawn request it samples the PRBS for an X and a Y candidate and rejects out-of-range values. It queries the body lookup, retries on collision and falls back to a deterministic grid scan. It then presents a registered, valid food coordinate.

## Interface
Parameters:
- GRID_W, 80, number of columns; legal x is 0..GRID_W-1 (GRID_W ≤ 128)
- GRID_H, 60, number of rows; legal y is 0..GRID_H-1 (GRID_H ≤ 128)
- DRAW_GAP, 7, cycles between PRBS samples (≥1); 7 gives fully refreshed 7-bit words
- MAX_TRIES, 15, rejected random candidates before switching to scan (≥1)

Ports:
- clock_25  in  1  system clock (25 MHz domain)
- reset  in  1  asynchronous, active-high reset
- spawn_req  in  1  single-cycle request from game FSM; honoured only when busy=0
- rnd  in  7  current PRBS output
- occ_req  out  1  occupancy query valid; held until occ_ack
- occ_x  out  7  queried column; stable while occ_req=1
- occ_y  out  7  queried row; stable while occ_req=1
- occ_ack  in  1  query answered; sampled only while occ_req=1
- occ_hit  in  1  1 = cell occupied by snake; valid with occ_ack
- food_x  out  7  food column (registered)
- food_y  out  7  food row (registered)
- food_valid  out  1  food_x/food_y hold a free, placed cell
- busy  out  1  spawn in progress
- spawn_fail  out  1  grid completely occupied; held until next accepted spawn_req

## Operation
- States: IDLE, WAIT_X, WAIT_Y, QUERY, SCAN.
- IDLE: spawn_req=1 → clear food_valid and spawn_fail, clear tries, load gap counter, go to WAIT_X, busy=1.
- WAIT_X: count DRAW_GAP cycles. On the last cycle, sample rnd into cand_x. If cand_x ≥ GRID_W, count a reject and stay in WAIT_X with the counter reloaded. Otherwise go to WAIT_Y.
- WAIT_Y: same procedure for cand_y against GRID_H. In range → QUERY. Out of range → count a reject and return to WAIT_X.
- QUERY: occ_req=1 with occ_x/occ_y = candidate.
  - occ_ack with occ_hit=0 → food_x/food_y ← candidate, food_valid=1, IDLE.
  - occ_hit=1 → count a reject and return to WAIT_X.
- Reject counting: tries increments on every reject (range or hit). When tries reaches MAX_TRIES, go to SCAN instead of WAIT_X.
- SCAN start point:
  - If both cand_x and cand_y were last sampled in range, start at the cell after (cand_x, cand_y).
  - Otherwise start at (0,0).
- SCAN loop: query the cell, using the same handshake as QUERY.
  - Free → place food, IDLE.
  - Hit → x+1. At x = GRID_W-1, wrap to x=0 and y+1. At y = GRID_H-1, wrap to y=0.
  - A scan counter counts queries. GRID_W×GRID_H consecutive hits → spawn_fail=1, food_valid=0, IDLE.
- spawn_req while busy=1 is ignored (not queued).
- occ_hit is ignored when occ_ack=0.

## Timing
- Reset values: occ_req=0, occ_x=0, occ_y=0, food_x=0, food_y=0, food_valid=0, busy=0, spawn_fail=0. State=IDLE, counters=0.
- Reset asserted mid-operation returns everything to reset values immediately. occ_req drops asynchronously. No partial food is latched.
- spawn_req is accepted at edge T. busy=1 and food_valid=0 from T.
- rnd is sampled at edge T+DRAW_GAP (x) and T+2·DRAW_GAP (y). occ_req is high from T+2·DRAW_GAP.
- occ_ack may arrive at the earliest one cycle after occ_req rises and may be delayed arbitrarily.
- Ack with hit=0 at edge A: food_x/food_y/food_valid update at A, busy=0 and occ_req=0 after A.
- Minimum spawn latency: 2·DRAW_GAP+1 cycles.
- After a hit, the next candidate's x sample occurs DRAW_GAP edges after the ack edge.
- SCAN: occ_req deasserts for exactly one cycle between consecutive queries, and occ_x/occ_y advance in that cycle.
- spawn_fail is asserted at the edge of the final hit ack.

## Test plan
- DRAW_GAP=7, GRID 80×60, MAX_TRIES=4: spawn_req at edge 0, rnd=25 at edge 7, rnd=40 at edge 14, ack hit=0 at edge 15 → occ (25,40), food (25,40), food_valid=1 at edge 15, busy=0.
- rnd=100 at edge 7, then rnd=30 at 14, 45 at 21, ack free → food (30,45). Out-of-range x costs exactly one DRAW_GAP.
- Candidate (10,10) hit, next candidate (11,12) free → two occ_req transactions, food (11,12). Extra spawn_req pulses while busy change nothing.
- Four hits, last candidate (79,59) → SCAN queries (0,0) first. Free → food (0,0), valid.
- All queries return hit → after 4800 scan queries spawn_fail=1, food_valid=0, busy=0. Next spawn_req clears spawn_fail.
- Reset asserted while occ_req=1 at candidate (5,6) → all outputs 0 immediately. After release, a fresh spawn_req completes normally.
